// File: rtl/vend_pkg.sv
// Shared types and constants for the change dispenser: FSM states, change codes
// and the request qualifier used by both the top and its pending slot.
package vend_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_VEND,
        S_COIN_PULSE,
        S_WAIT_ACK,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [1:0] R0  = 2'b00;
    localparam logic [1:0] R5  = 2'b01;
    localparam logic [1:0] R10 = 2'b10;
    localparam logic [1:0] R15 = 2'b11;

    localparam int COIN_VALUE = 5;

    // A cycle with no purchase and no change owed carries nothing to do.
    function automatic logic is_request(input logic buy, input logic [1:0] chg);
        return buy || (chg != R0);
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Bundle between the vending controller / hopper side (master) and the
// change dispenser (slave).
interface change_dispenser_if;
    logic       buy;
    logic [1:0] chg;
    logic       coin_ack;
    logic       fault_clr;
    logic       vend_motor;
    logic       coin_out;
    logic       busy;
    logic       done;
    logic       fault;
    logic       overflow;
    logic [1:0] coins_left;

    modport master (
        output buy, chg, coin_ack, fault_clr,
        input  vend_motor, coin_out, busy, done, fault, overflow, coins_left
    );

    modport slave (
        input  buy, chg, coin_ack, fault_clr,
        output vend_motor, coin_out, busy, done, fault, overflow, coins_left
    );
endinterface

// File: rtl/change_dispenser_cycle_timer.sv
// State-duration timer: load starts the count at 1 for the first cycle in a
// state; expired flags the LEN-th cycle. The count saturates at LEN.
module cycle_timer #(
    parameter int LEN = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    output logic expired
);
    localparam int CW = $clog2(LEN + 1);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= CW'(1);
        end else if (cnt_reg != CW'(LEN)) begin
            cnt_reg <= cnt_reg + CW'(1);
        end
    end

    assign expired = (cnt_reg == CW'(LEN));

endmodule

// File: rtl/change_dispenser.sv
// Turns buy/change transactions into product-motor and coin-release pulses,
// handshakes each coin with the hopper, buffers one request, faults on timeout.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int VEND_W      = 8,
    parameter int PULSE_W     = 4,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset,
    change_dispenser_if.slave  bus
);
    localparam int NTIMER = 3;
    localparam state_t TIMED_STATE [NTIMER] = '{S_VEND, S_COIN_PULSE, S_WAIT_ACK};
    localparam int     TIMER_LEN   [NTIMER] = '{VEND_W, PULSE_W, ACK_TIMEOUT};

    state_t      state_reg, state_next;
    logic        pend_valid_reg, pend_buy_reg;
    logic [1:0]  pend_chg_reg;
    logic [1:0]  coins_left_reg;
    logic        ack_d_reg;
    logic        overflow_reg;
    logic        vend_motor_reg, coin_out_reg, busy_reg, done_reg, fault_reg;

    logic        req_live, src_valid, src_buy, ack_rise;
    logic [1:0]  src_chg;
    logic [NTIMER-1:0] timer_exp;

    assign req_live  = is_request(bus.buy, bus.chg);
    assign src_valid = pend_valid_reg || req_live;
    assign src_buy   = pend_valid_reg ? pend_buy_reg : bus.buy;
    assign src_chg   = pend_valid_reg ? pend_chg_reg : bus.chg;
    assign ack_rise  = bus.coin_ack && !ack_d_reg;

    // Each timed state reloads its timer on entry so its first cycle counts as 1.
    for (genvar gi = 0; gi < NTIMER; gi++) begin : g_timer
        cycle_timer #(.LEN(TIMER_LEN[gi])) u_timer (
            .clock   (clock),
            .reset   (reset),
            .load    ((state_next == TIMED_STATE[gi]) && (state_reg != TIMED_STATE[gi])),
            .expired (timer_exp[gi])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (src_valid) begin
                    state_next = src_buy ? S_VEND : S_COIN_PULSE;
                end
            end
            S_VEND: begin
                if (timer_exp[0]) begin
                    state_next = (coins_left_reg == R0) ? S_DONE : S_COIN_PULSE;
                end
            end
            S_COIN_PULSE: begin
                if (timer_exp[1]) begin
                    state_next = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (ack_rise) begin
                    state_next = (coins_left_reg == R5) ? S_DONE : S_COIN_PULSE;
                end else if (timer_exp[2]) begin
                    state_next = S_FAULT;
                end
            end
            S_DONE:  state_next = S_IDLE;
            S_FAULT: begin
                if (bus.fault_clr) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vend_motor_reg <= 1'b0;
            coin_out_reg   <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            fault_reg      <= 1'b0;
            ack_d_reg      <= 1'b0;
        end else begin
            vend_motor_reg <= (state_next == S_VEND);
            coin_out_reg   <= (state_next == S_COIN_PULSE);
            busy_reg       <= (state_next != S_IDLE);
            done_reg       <= (state_next == S_DONE);
            fault_reg      <= (state_next == S_FAULT);
            ack_d_reg      <= bus.coin_ack;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            coins_left_reg <= R0;
            pend_valid_reg <= 1'b0;
            pend_buy_reg   <= 1'b0;
            pend_chg_reg   <= R0;
            overflow_reg   <= 1'b0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (src_valid) begin
                        coins_left_reg <= src_chg;
                    end
                    // Consuming the slot frees it for a request arriving this same cycle.
                    if (pend_valid_reg) begin
                        pend_valid_reg <= req_live;
                        pend_buy_reg   <= bus.buy;
                        pend_chg_reg   <= bus.chg;
                    end
                end
                S_FAULT: begin
                    if (req_live) begin
                        overflow_reg <= 1'b1;
                    end
                    if (bus.fault_clr) begin
                        pend_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    if (state_reg == S_WAIT_ACK && ack_rise) begin
                        coins_left_reg <= coins_left_reg - 2'd1;
                    end
                    if (req_live) begin
                        if (!pend_valid_reg) begin
                            pend_valid_reg <= 1'b1;
                            pend_buy_reg   <= bus.buy;
                            pend_chg_reg   <= bus.chg;
                        end else begin
                            overflow_reg <= 1'b1;
                        end
                    end
                end
            endcase
            if (bus.fault_clr) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign bus.vend_motor = vend_motor_reg;
    assign bus.coin_out   = coin_out_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
    assign bus.fault      = fault_reg;
    assign bus.overflow   = overflow_reg;
    assign bus.coins_left = coins_left_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: table-driven and random transactions against a
// timing formula, plus hand sequences for timeout, overflow, held ack and reset.
module tb_change_dispenser;
    localparam int VEND_W      = 8;
    localparam int PULSE_W     = 4;
    localparam int ACK_TIMEOUT = 255;

    logic clock;
    logic reset;
    change_dispenser_if bus();

    change_dispenser #(
        .VEND_W(VEND_W), .PULSE_W(PULSE_W), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic       buy;
        logic [1:0] chg;
        int         ack_delay;
        int         exp_vend;
        int         exp_pulses;
        int         exp_done_rel;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // Observation state; rel counts edges since the request was sampled.
    int rel, vend_cnt, pulse_cnt, coin_hi, done_cnt, first_done_rel, last_done_rel;
    int wait_cnt, ack_delay, hold_left, start_coins, start_vend, start_coin, done_coins;
    bit prev_coin, hold_mode, hold_used;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // One clock, sampled 1 time unit after the edge; also plays the hopper.
    task automatic obs_step;
        @(posedge clock);
        #1;
        rel++;
        if (bus.vend_motor) vend_cnt++;
        if (bus.coin_out) coin_hi++;
        if (bus.coin_out && !prev_coin) begin
            pulse_cnt++;
            wait_cnt = 0;
        end else if (!bus.coin_out && prev_coin) begin
            wait_cnt = 1;
        end else if (wait_cnt > 0) begin
            wait_cnt++;
        end
        prev_coin = bus.coin_out;
        if (rel == 1) begin
            start_coins = int'(bus.coins_left);
            start_vend  = int'(bus.vend_motor);
            start_coin  = int'(bus.coin_out);
        end
        if (bus.done) begin
            done_cnt++;
            if (first_done_rel == 0) first_done_rel = rel;
            last_done_rel = rel;
            done_coins = int'(bus.coins_left);
        end
        if (hold_mode && !hold_used && pulse_cnt == 1 && wait_cnt == 1) begin
            hold_left = 6;
            hold_used = 1'b1;
        end
        if (hold_left > 0) begin
            bus.coin_ack = 1'b1;
            hold_left--;
        end else begin
            bus.coin_ack = (ack_delay != 0) && (wait_cnt == ack_delay);
        end
    endtask

    task automatic start_txn(input logic b, input logic [1:0] c, input int a);
        rel = 0; vend_cnt = 0; pulse_cnt = 0; coin_hi = 0; done_cnt = 0;
        first_done_rel = 0; last_done_rel = 0; wait_cnt = 0; prev_coin = 1'b0;
        hold_used = 1'b0; hold_left = 0; done_coins = -1; ack_delay = a;
        bus.buy = b;
        bus.chg = c;
        obs_step;
        bus.buy = 1'b0;
        bus.chg = 2'b00;
    endtask

    task automatic run_txn(input logic b, input logic [1:0] c, input int a,
                           input int exp_vend, input int exp_pulses, input int exp_rel);
        start_txn(b, c, a);
        while (done_cnt == 0 && rel < 600) obs_step;
        obs_step;
        chk("busy_after_done", int'(bus.busy), 0);
        obs_step;
        chk("first_vend", start_vend, int'(b));
        chk("first_coin", start_coin, int'(!b));
        chk("coins_at_start", start_coins, int'(c));
        chk("vend_cycles", vend_cnt, exp_vend);
        chk("coin_pulses", pulse_cnt, exp_pulses);
        chk("coin_high_cycles", coin_hi, exp_pulses * PULSE_W);
        chk("done_count", done_cnt, 1);
        chk("done_latency", first_done_rel, exp_rel);
        chk("coins_at_done", done_coins, 0);
        $display("txn buy=%0d chg=%0d ack=%0d done_rel=%0d exp=%0d",
                 b, c, a, first_done_rel, exp_rel);
    endtask

    vec_t vecs [6];
    logic       rb;
    logic [1:0] rc;
    int         ra, rv;

    initial begin
        vecs[0] = '{1'b1, 2'd1, 2, 8, 1, 15};
        vecs[1] = '{1'b0, 2'd2, 1, 0, 2, 11};
        vecs[2] = '{1'b1, 2'd0, 1, 8, 0, 9};
        vecs[3] = '{1'b1, 2'd3, 3, 8, 3, 30};
        vecs[4] = '{1'b0, 2'd1, 5, 0, 1, 10};
        vecs[5] = '{1'b0, 2'd3, 1, 0, 3, 16};

        reset = 1'b1;
        bus.buy = 1'b0; bus.chg = 2'b00; bus.coin_ack = 1'b0; bus.fault_clr = 1'b0;
        hold_mode = 1'b0; ack_delay = 0; prev_coin = 1'b0; wait_cnt = 0; hold_left = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(posedge clock);
        #1;
        chk("reset_outputs", int'({bus.vend_motor, bus.coin_out, bus.busy, bus.done,
                                   bus.fault, bus.overflow, bus.coins_left}), 0);
        $display("txn reset state checked");

        for (int i = 0; i < 6; i++) begin
            run_txn(vecs[i].buy, vecs[i].chg, vecs[i].ack_delay,
                    vecs[i].exp_vend, vecs[i].exp_pulses, vecs[i].exp_done_rel);
        end

        for (int i = 0; i < 20; i++) begin
            rb = 1'($urandom_range(0, 1));
            rc = 2'($urandom_range(0, 3));
            if (!rb && rc == 2'd0) rc = 2'd1;
            ra = int'($urandom_range(1, 8));
            rv = rb ? VEND_W : 0;
            run_txn(rb, rc, ra, rv, int'(rc), 1 + rv + int'(rc) * (PULSE_W + ra));
        end

        // Hopper never answers: one pulse, then fault after the full ack window.
        start_txn(1'b0, 2'd3, 0);
        while (!bus.fault && rel < 400) obs_step;
        chk("timeout_rel", rel, 1 + PULSE_W + ACK_TIMEOUT);
        chk("fault_coins_left", int'(bus.coins_left), 3);
        chk("fault_pulses", pulse_cnt, 1);
        chk("fault_coin_out", int'(bus.coin_out), 0);
        chk("fault_busy", int'(bus.busy), 1);
        chk("ovf_before_drop", int'(bus.overflow), 0);
        bus.buy = 1'b1;
        obs_step;
        bus.buy = 1'b0;
        chk("fault_drop_ovf", int'(bus.overflow), 1);
        chk("fault_held", int'(bus.fault), 1);
        bus.fault_clr = 1'b1;
        obs_step;
        bus.fault_clr = 1'b0;
        chk("clr_fault", int'(bus.fault), 0);
        chk("clr_busy", int'(bus.busy), 0);
        chk("clr_ovf", int'(bus.overflow), 0);
        $display("txn timeout fault_rel=%0d", 1 + PULSE_W + ACK_TIMEOUT);
        obs_step;

        // Two requests while busy: first waits in the slot, second is dropped.
        start_txn(1'b1, 2'd0, 2);
        obs_step;
        bus.chg = 2'd1;
        obs_step;
        bus.chg = 2'd0;
        bus.buy = 1'b1;
        obs_step;
        bus.buy = 1'b0;
        chk("ovf_set", int'(bus.overflow), 1);
        while (rel < 40) obs_step;
        chk("b2b_first_done", first_done_rel, 1 + VEND_W);
        chk("b2b_done_count", done_cnt, 2);
        chk("b2b_second_done", last_done_rel, 1 + VEND_W + 2 + PULSE_W + 2);
        chk("b2b_vend_cycles", vend_cnt, VEND_W);
        chk("b2b_pulses", pulse_cnt, 1);
        chk("ovf_sticky", int'(bus.overflow), 1);
        $display("txn back-to-back dones=%0d last_done_rel=%0d", done_cnt, last_done_rel);

        // Ack held across the next pulse into the next wait counts only once.
        hold_mode = 1'b1;
        run_txn(1'b0, 2'd3, 3, 0, 3, 1 + (PULSE_W + 1) + 2 * (PULSE_W + 3));
        hold_mode = 1'b0;

        // Asynchronous reset in the middle of a coin pulse.
        start_txn(1'b0, 2'd1, 2);
        obs_step;
        chk("pre_reset_coin", int'(bus.coin_out), 1);
        #2 reset = 1'b1;
        #1;
        chk("reset_coin_drop", int'(bus.coin_out), 0);
        chk("reset_busy_drop", int'(bus.busy), 0);
        @(posedge clock);
        #1 reset = 1'b0;
        done_cnt = 0;
        repeat (20) obs_step;
        chk("reset_no_done", done_cnt, 0);
        chk("reset_idle", int'(bus.busy), 0);
        chk("reset_ovf", int'(bus.overflow), 0);
        chk("reset_coins", int'(bus.coins_left), 0);
        $display("txn mid-pulse reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
